mips_decode_buffer: RTL and testbench

Decode-stage instruction buffer between fetch and the ID/EX pipeline register. It queues raw fetched instructions with their PCs in a DEPTH-entry FIFO. It decodes the head entry into a packed control bundle and presents it downstream over a valid/ready handshake. Generalised over DEPTH and XLEN (32/64). When XLEN=32, 64-bit d-ops become reserved. After a reserved instruction leaves, a halt state holds the stage until the pipeline flushes.

---
 rtl/mips_decode_buffer_pkg.sv | 72 +++++++
 rtl/mips_define.sv | 68 ++++++
 rtl/mips_decode_core.sv | 189 ++++++++++++++++++
 rtl/mips_decode_buffer.sv | 144 ++++++++++++++
 tb/tb_mips_decode_buffer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_decode_buffer_pkg.sv
// mips_decode_buffer_pkg: control-bundle types, ALU/operand encodings and
// buffer state enum shared by the decode buffer and its decoder.
package mips_decode_buffer_pkg;

    localparam int unsigned INST_W = 32;

    // alu_op encodings
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_XOR   = 3'd4;
    localparam logic [2:0] ALU_NOR   = 3'd5;
    localparam logic [2:0] ALU_SLT   = 3'd6;
    localparam logic [2:0] ALU_SHIFT = 3'd7;

    // alu_src2 encodings: rt register, sign/zero-extended imm, imm << 16
    localparam logic [1:0] SRC2_RT   = 2'd0;
    localparam logic [1:0] SRC2_SEXT = 2'd1;
    localparam logic [1:0] SRC2_ZEXT = 2'd2;
    localparam logic [1:0] SRC2_LUI  = 2'd3;

    // rd_src: destination from rd field (R-type) or rt field (I-type)
    localparam logic RD_FROM_RD = 1'b0;
    localparam logic RD_FROM_RT = 1'b1;

    typedef enum logic [1:0] {CT_NONE, CT_BRANCH, CT_JUMP, CT_JUMP_REG} control_type_t;
    typedef enum logic [2:0] {ST_NONE, ST_BYTE, ST_HALF, ST_WORD, ST_DWORD} mem_store_type_t;
    typedef enum logic [2:0] {LD_NONE, LD_BYTE, LD_HALF, LD_WORD, LD_DWORD} mem_load_type_t;
    typedef enum logic [1:0] {SLT_NONE, SLT_SIGNED, SLT_UNSIGNED} slt_type_t;
    typedef enum logic [1:0] {SH_NONE, SH_LL, SH_RL, SH_RA} shift_type_t;

    // [1]: truncate result to 32 bits and sign-extend; [0]: shift the low 32 bits of the source
    typedef logic [1:0] alu_cut_t;

    typedef struct packed {
        logic [2:0]      alu_op;
        logic            writeenable;
        logic            rd_src;
        logic [1:0]      alu_src2;
        control_type_t   control_type;
        mem_store_type_t mem_store_type;
        mem_load_type_t  mem_load_type;
        slt_type_t       slt_type;
        alu_cut_t        cut_alu_out32;
        shift_type_t     shift_type;
        logic            shift_var;
        logic            shift_plus32;
        logic            is_mfc0;
        logic            is_mtc0;
        logic            is_eret;
        logic            is_beq;
        logic            is_bne;
        logic            is_bc;
        logic            signed_byte;   // sign-extend sub-word (byte/half) load
        logic            signed_word;   // sign-extend 32-bit word load
        logic            ignore_overflow;
    } decode_ctrl_t;

    typedef enum logic {RUN, HALT} dbuf_state_t;

    // Shift direction from the low two funct bits shared by all shift encodings
    function automatic shift_type_t shift_of(input logic [1:0] f);
        case (f)
            2'b00:   return SH_LL;
            2'b10:   return SH_RL;
            2'b11:   return SH_RA;
            default: return SH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mips_define.sv
// mips_define: MIPS opcode, funct and COP0 field encodings used by the decoder.
package mips_define;

    // Primary opcodes (inst[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] OP_DADDI   = 6'h18;
    localparam logic [5:0] OP_DADDIU  = 6'h19;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_LWU     = 6'h27;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] OP_LD      = 6'h37;
    localparam logic [5:0] OP_SD      = 6'h3F;

    // SPECIAL funct codes (inst[5:0])
    localparam logic [5:0] FN_SLL    = 6'h00;
    localparam logic [5:0] FN_SRL    = 6'h02;
    localparam logic [5:0] FN_SRA    = 6'h03;
    localparam logic [5:0] FN_SLLV   = 6'h04;
    localparam logic [5:0] FN_SRLV   = 6'h06;
    localparam logic [5:0] FN_SRAV   = 6'h07;
    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_JALR   = 6'h09;
    localparam logic [5:0] FN_ADD    = 6'h20;
    localparam logic [5:0] FN_ADDU   = 6'h21;
    localparam logic [5:0] FN_SUB    = 6'h22;
    localparam logic [5:0] FN_SUBU   = 6'h23;
    localparam logic [5:0] FN_AND    = 6'h24;
    localparam logic [5:0] FN_OR     = 6'h25;
    localparam logic [5:0] FN_XOR    = 6'h26;
    localparam logic [5:0] FN_NOR    = 6'h27;
    localparam logic [5:0] FN_SLT    = 6'h2A;
    localparam logic [5:0] FN_SLTU   = 6'h2B;
    localparam logic [5:0] FN_DADD   = 6'h2C;
    localparam logic [5:0] FN_DADDU  = 6'h2D;
    localparam logic [5:0] FN_DSUB   = 6'h2E;
    localparam logic [5:0] FN_DSLL   = 6'h38;
    localparam logic [5:0] FN_DSRL   = 6'h3A;
    localparam logic [5:0] FN_DSLL32 = 6'h3C;
    localparam logic [5:0] FN_DSRL32 = 6'h3E;

    // REGIMM rt codes and COP0 rs / funct codes
    localparam logic [4:0] RT_BLTZ = 5'h00;
    localparam logic [4:0] RT_BGEZ = 5'h01;
    localparam logic [4:0] RS_MF   = 5'h00;
    localparam logic [4:0] RS_MT   = 5'h04;
    localparam logic [5:0] FN_ERET = 6'h18;

endpackage

// File: rtl/mips_decode_core.sv
// mips_decode_core: combinational MIPS decoder, inst -> {decode_ctrl_t, except}.
// Ports: inst (32-bit raw word), ctrl (control bundle, zero when except), except
// (unrecognised encoding, or 64-bit op when XLEN=32).
module mips_decode_core
    import mips_define::*;
    import mips_decode_buffer_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0]  inst,
    output decode_ctrl_t ctrl,
    output logic         except
);

    localparam logic     IS64      = (XLEN == 64);
    localparam alu_cut_t CUT_ARITH = IS64 ? 2'b10 : 2'b00;
    localparam alu_cut_t CUT_SHIFT = IS64 ? 2'b11 : 2'b00;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;

    assign opcode = inst[31:26];
    assign rs     = inst[25:21];
    assign rt     = inst[20:16];
    assign funct  = inst[5:0];

    decode_ctrl_t c;
    logic         illegal;
    logic         dop;

    // Field decode; dop marks 64-bit-only operations
    always_comb begin
        c       = '0;
        illegal = 1'b0;
        dop     = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                c.writeenable = 1'b1;
                c.rd_src      = RD_FROM_RD;
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: begin
                        c.alu_op        = ALU_SHIFT;
                        c.shift_type    = shift_of(funct[1:0]);
                        c.shift_var     = funct[2];
                        c.cut_alu_out32 = CUT_SHIFT;
                    end
                    FN_DSLL, FN_DSRL, FN_DSLL32, FN_DSRL32: begin
                        dop            = 1'b1;
                        c.alu_op       = ALU_SHIFT;
                        c.shift_type   = shift_of(funct[1:0]);
                        c.shift_plus32 = funct[2];
                    end
                    FN_JR: begin
                        c.writeenable  = 1'b0;
                        c.control_type = CT_JUMP_REG;
                    end
                    FN_JALR: c.control_type = CT_JUMP_REG;
                    FN_ADD, FN_ADDU: begin
                        c.alu_op          = ALU_ADD;
                        c.cut_alu_out32   = CUT_ARITH;
                        c.ignore_overflow = funct[0];
                    end
                    FN_SUB, FN_SUBU: begin
                        c.alu_op          = ALU_SUB;
                        c.cut_alu_out32   = CUT_ARITH;
                        c.ignore_overflow = funct[0];
                    end
                    FN_DADD, FN_DADDU: begin
                        dop               = 1'b1;
                        c.alu_op          = ALU_ADD;
                        c.ignore_overflow = funct[0];
                    end
                    FN_DSUB: begin
                        dop      = 1'b1;
                        c.alu_op = ALU_SUB;
                    end
                    FN_AND:  c.alu_op = ALU_AND;
                    FN_OR:   c.alu_op = ALU_OR;
                    FN_XOR:  c.alu_op = ALU_XOR;
                    FN_NOR:  c.alu_op = ALU_NOR;
                    FN_SLT: begin
                        c.alu_op   = ALU_SLT;
                        c.slt_type = SLT_SIGNED;
                    end
                    FN_SLTU: begin
                        c.alu_op   = ALU_SLT;
                        c.slt_type = SLT_UNSIGNED;
                    end
                    default: illegal = 1'b1;
                endcase
                // all-zero word is the canonical NOP: legal, no writeback
                if (inst == 32'h0) c.writeenable = 1'b0;
            end
            OP_REGIMM: begin
                if (rt == RT_BLTZ || rt == RT_BGEZ) begin
                    c.control_type = CT_BRANCH;
                    c.is_bc        = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_J:   c.control_type = CT_JUMP;
            OP_JAL: begin
                c.control_type = CT_JUMP;
                c.writeenable  = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                c.control_type = CT_BRANCH;
                c.alu_op       = ALU_SUB;
                c.is_beq       = ~opcode[0];
                c.is_bne       = opcode[0];
            end
            OP_ADDI, OP_ADDIU, OP_DADDI, OP_DADDIU: begin
                dop               = opcode[4];
                c.writeenable     = 1'b1;
                c.rd_src          = RD_FROM_RT;
                c.alu_src2        = SRC2_SEXT;
                c.alu_op          = ALU_ADD;
                c.cut_alu_out32   = opcode[4] ? 2'b00 : CUT_ARITH;
                c.ignore_overflow = opcode[0];
            end
            OP_SLTI, OP_SLTIU: begin
                c.writeenable = 1'b1;
                c.rd_src      = RD_FROM_RT;
                c.alu_src2    = SRC2_SEXT;
                c.alu_op      = ALU_SLT;
                c.slt_type    = opcode[0] ? SLT_UNSIGNED : SLT_SIGNED;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                c.writeenable = 1'b1;
                c.rd_src      = RD_FROM_RT;
                c.alu_src2    = SRC2_ZEXT;
                c.alu_op      = (opcode == OP_ANDI) ? ALU_AND :
                                (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
            end
            OP_LUI: begin
                c.writeenable = 1'b1;
                c.rd_src      = RD_FROM_RT;
                c.alu_src2    = SRC2_LUI;
                c.alu_op      = ALU_ADD;
            end
            OP_COP0: begin
                if (rs == RS_MF) begin
                    c.is_mfc0     = 1'b1;
                    c.writeenable = 1'b1;
                    c.rd_src      = RD_FROM_RT;
                end else if (rs == RS_MT) begin
                    c.is_mtc0 = 1'b1;
                end else if (rs[4] && funct == FN_ERET) begin
                    c.is_eret = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU, OP_LD: begin
                dop               = (opcode == OP_LWU) || (opcode == OP_LD);
                c.writeenable     = 1'b1;
                c.rd_src          = RD_FROM_RT;
                c.alu_src2        = SRC2_SEXT;
                c.alu_op          = ALU_ADD;
                c.ignore_overflow = 1'b1;
                c.mem_load_type   = (opcode == OP_LB || opcode == OP_LBU) ? LD_BYTE :
                                    (opcode == OP_LH || opcode == OP_LHU) ? LD_HALF :
                                    (opcode == OP_LD)                     ? LD_DWORD : LD_WORD;
                c.signed_byte     = (opcode == OP_LB) || (opcode == OP_LH);
                c.signed_word     = (opcode == OP_LW);
            end
            OP_SB, OP_SH, OP_SW, OP_SD: begin
                dop               = (opcode == OP_SD);
                c.alu_src2        = SRC2_SEXT;
                c.alu_op          = ALU_ADD;
                c.ignore_overflow = 1'b1;
                c.mem_store_type  = (opcode == OP_SB) ? ST_BYTE :
                                    (opcode == OP_SH) ? ST_HALF :
                                    (opcode == OP_SD) ? ST_DWORD : ST_WORD;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Excepting instructions carry no enables downstream
    always_comb begin
        except = illegal || (dop && !IS64);
        ctrl   = except ? decode_ctrl_t'('0) : c;
    end

endmodule

// File: rtl/mips_decode_buffer.sv
// mips_decode_buffer: decode-stage FIFO between fetch and ID/EX. Queues
// {inst, pc}, decodes the head entry and offers it over valid/ready. Popping an
// excepting instruction or ERET halts the stage until flush.
// Ports: clock, reset (sync, active-high); in_valid/in_ready/in_inst/in_pc
// (fetch side); flush; out_valid/out_ready/out_inst/out_pc/out_ctrl/out_except
// (head, combinational); count; stat_decoded/stat_except.
// Optional: define MIPS_DECODE_STATS_EN to build the pop/exception counters;
// otherwise both stat ports read 0.
module mips_decode_buffer
    import mips_decode_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [XLEN-1:0]            in_pc,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [XLEN-1:0]            out_pc,
    output decode_ctrl_t               out_ctrl,
    output logic                       out_except,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [31:0]                stat_decoded,
    output logic [31:0]                stat_except
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("mips_decode_buffer: XLEN must be 32 or 64");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mips_decode_buffer: DEPTH must be a power of two >= 2");
    end

    logic [31:0]      inst_mem [DEPTH];
    logic [XLEN-1:0]  pc_mem   [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    dbuf_state_t      state_q;
    dbuf_state_t      state_d;
    logic             enter_halt;
    logic             push;
    logic             pop;
    decode_ctrl_t     head_ctrl;
    logic             head_except;

    // Handshakes; in_ready deliberately ignores out_ready
    assign in_ready  = (state_q == RUN) && (count_q != CNT_W'(DEPTH));
    assign out_valid = (state_q == RUN) && (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    // Head entry and its decode
    assign out_inst = inst_mem[rd_ptr_q];
    assign out_pc   = pc_mem[rd_ptr_q];

    mips_decode_core #(.XLEN(XLEN)) u_decode (
        .inst   (out_inst),
        .ctrl   (head_ctrl),
        .except (head_except)
    );

    assign out_ctrl   = out_valid ? head_ctrl : decode_ctrl_t'('0);
    assign out_except = out_valid && head_except;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    // Next state: except/ERET pop halts; flush always returns to RUN
    always_comb begin
        state_d    = state_q;
        enter_halt = 1'b0;
        case (state_q)
            RUN: begin
                if (pop && (head_except || head_ctrl.is_eret)) begin
                    state_d    = HALT;
                    enter_halt = 1'b1;
                end
            end
            HALT: state_d = HALT;
        endcase
        if (flush) begin
            state_d    = RUN;
            enter_halt = 1'b0;
        end
    end

    // Pointers and occupancy; flush and halt entry discard everything queued
    always_ff @(posedge clock) begin
        if (reset || flush || enter_halt) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Entry storage
    always_ff @(posedge clock) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= in_inst;
            pc_mem[wr_ptr_q]   <= in_pc;
        end
    end

`ifdef MIPS_DECODE_STATS_EN
    logic [31:0] stat_decoded_q;
    logic [31:0] stat_except_q;

    // Handed-downstream counters; a flushed pop does not count
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_decoded_q <= '0;
            stat_except_q  <= '0;
        end else if (pop && !flush) begin
            stat_decoded_q <= stat_decoded_q + 32'd1;
            if (out_except) stat_except_q <= stat_except_q + 32'd1;
        end
    end

    assign stat_decoded = stat_decoded_q;
    assign stat_except  = stat_except_q;
`else
    assign stat_decoded = '0;
    assign stat_except  = '0;
`endif

endmodule

// File: tb/tb_mips_decode_buffer.sv
// tb_mips_decode_buffer: directed bench for mips_decode_buffer with one
// DEPTH=4/XLEN=64 instance (a_*) and one DEPTH=4/XLEN=32 instance (b_*).
module tb_mips_decode_buffer;
    import mips_decode_buffer_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
`ifdef MIPS_DECODE_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    localparam logic [31:0] I_ADDU  = 32'h0022_1821;
    localparam logic [31:0] I_DADDU = 32'h0022_182D;
    localparam logic [31:0] I_LUI   = 32'h3C01_1234;
    localparam logic [31:0] I_ERET  = 32'h4200_0018;
    localparam logic [31:0] I_BAD   = 32'h7C00_0000;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    logic             a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_out_except;
    logic [31:0]      a_in_inst, a_out_inst, a_stat_decoded, a_stat_except;
    logic [63:0]      a_in_pc, a_out_pc;
    decode_ctrl_t     a_out_ctrl;
    logic [CNT_W-1:0] a_count;

    logic             b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_out_except;
    logic [31:0]      b_in_inst, b_out_inst, b_stat_decoded, b_stat_except;
    logic [31:0]      b_in_pc, b_out_pc;
    decode_ctrl_t     b_out_ctrl;
    logic [CNT_W-1:0] b_count;

    mips_decode_buffer #(.DEPTH(DEPTH), .XLEN(64)) dut_a (
        .clock(clock), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inst(a_in_inst), .in_pc(a_in_pc),
        .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_inst(a_out_inst), .out_pc(a_out_pc),
        .out_ctrl(a_out_ctrl), .out_except(a_out_except), .count(a_count),
        .stat_decoded(a_stat_decoded), .stat_except(a_stat_except)
    );

    mips_decode_buffer #(.DEPTH(DEPTH), .XLEN(32)) dut_b (
        .clock(clock), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inst(b_in_inst), .in_pc(b_in_pc),
        .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_inst(b_out_inst), .out_pc(b_out_pc),
        .out_ctrl(b_out_ctrl), .out_except(b_out_except), .count(b_count),
        .stat_decoded(b_stat_decoded), .stat_except(b_stat_except)
    );

    int vectors    = 0;
    int miscompares = 0;
    decode_ctrl_t e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Stats expectation depends on whether the counters were built
    function automatic logic [63:0] st(input int n);
        return STATS_ON ? 64'(n) : 64'd0;
    endfunction

    // Advance one clock; sampling and driving happen 1ns after the rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0; a_in_inst = '0; a_in_pc = '0;
        b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0; b_in_inst = '0; b_in_pc = '0;
        tick();
        tick();

        // ---- reset state ----
        chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_a_in_ready", 64'(a_in_ready), 64'd1);
        chk("rst_a_out_except", 64'(a_out_except), 64'd0);
        chk("rst_a_out_ctrl", 64'(a_out_ctrl), 64'd0);
        chk("rst_a_count", 64'(a_count), 64'd0);
        chk("rst_a_stat_decoded", 64'(a_stat_decoded), 64'd0);
        chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
        chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        reset = 1'b0;

        // ---- XLEN=32: daddu is reserved, pop halts, flush resumes ----
        b_in_valid = 1'b1; b_in_inst = I_DADDU; b_in_pc = 32'h80;
        tick();
        b_in_inst = I_ADDU; b_in_pc = 32'h84;
        chk("b_daddu_valid", 64'(b_out_valid), 64'd1);
        chk("b_daddu_except", 64'(b_out_except), 64'd1);
        chk("b_daddu_ctrl", 64'(b_out_ctrl), 64'd0);
        chk("b_daddu_pc", 64'(b_out_pc), 64'h80);
        tick();
        chk("b_count2", 64'(b_count), 64'd2);
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        tick();
        chk("b_halt_out_valid", 64'(b_out_valid), 64'd0);
        chk("b_halt_in_ready", 64'(b_in_ready), 64'd0);
        chk("b_halt_count", 64'(b_count), 64'd0);
        chk("b_stat_except", 64'(b_stat_except), st(1));
        b_out_ready = 1'b0; b_flush = 1'b1;
        tick();
        b_flush = 1'b0;
        chk("b_flush_in_ready", 64'(b_in_ready), 64'd1);
        chk("b_flush_count", 64'(b_count), 64'd0);
        b_in_valid = 1'b1; b_in_inst = I_ADDU; b_in_pc = 32'h90;
        tick();
        b_in_valid = 1'b0;
        e = '0; e.alu_op = ALU_ADD; e.writeenable = 1'b1; e.ignore_overflow = 1'b1;
        chk("b_addu_except", 64'(b_out_except), 64'd0);
        chk("b_addu_ctrl_nocut", 64'(b_out_ctrl), 64'(e));
        chk("b_addu_pc", 64'(b_out_pc), 64'h90);

        // ---- XLEN=64: addu latency and decode ----
        a_in_valid = 1'b1; a_in_inst = I_ADDU; a_in_pc = 64'h100;
        chk("a_empty_out_valid", 64'(a_out_valid), 64'd0);
        tick();
        a_in_valid = 1'b0;
        e = '0; e.alu_op = ALU_ADD; e.writeenable = 1'b1; e.ignore_overflow = 1'b1;
        e.cut_alu_out32 = 2'b10;
        chk("a_addu_valid", 64'(a_out_valid), 64'd1);
        chk("a_addu_pc", 64'(a_out_pc), 64'h100);
        chk("a_addu_inst", 64'(a_out_inst), 64'(I_ADDU));
        chk("a_addu_ctrl", 64'(a_out_ctrl), 64'(e));
        chk("a_addu_except", 64'(a_out_except), 64'd0);
        chk("a_addu_count", 64'(a_count), 64'd1);
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        chk("a_flush1_count", 64'(a_count), 64'd0);
        chk("a_flush1_out_valid", 64'(a_out_valid), 64'd0);

        // ---- fill to DEPTH, refuse 5th, drain with wrap ----
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1'b1;
            a_in_inst = 32'h2401_0000 | 32'(i);
            a_in_pc = 64'h200 + 64'(4 * i);
            chk($sformatf("a_fill_in_ready_%0d", i), 64'(a_in_ready), (i < 4) ? 64'd1 : 64'd0);
            tick();
        end
        chk("a_full_count", 64'(a_count), 64'd4);
        chk("a_full_in_ready", 64'(a_in_ready), 64'd0);
        chk("a_full_head_pc", 64'(a_out_pc), 64'h200);
        a_out_ready = 1'b1;
        chk("a_full_pop_in_ready", 64'(a_in_ready), 64'd0);
        tick();
        chk("a_drain1_count", 64'(a_count), 64'd3);
        chk("a_drain1_pc", 64'(a_out_pc), 64'h204);
        chk("a_drain1_in_ready", 64'(a_in_ready), 64'd1);
        tick();
        a_in_valid = 1'b0;
        chk("a_drain2_count", 64'(a_count), 64'd3);
        chk("a_drain2_pc", 64'(a_out_pc), 64'h208);
        tick();
        chk("a_drain3_count", 64'(a_count), 64'd2);
        chk("a_drain3_pc", 64'(a_out_pc), 64'h20C);
        tick();
        e = '0; e.alu_op = ALU_ADD; e.writeenable = 1'b1; e.rd_src = RD_FROM_RT;
        e.alu_src2 = SRC2_SEXT; e.cut_alu_out32 = 2'b10; e.ignore_overflow = 1'b1;
        chk("a_wrap_count", 64'(a_count), 64'd1);
        chk("a_wrap_pc", 64'(a_out_pc), 64'h210);
        chk("a_wrap_inst", 64'(a_out_inst), 64'h2401_0004);
        chk("a_addiu_ctrl", 64'(a_out_ctrl), 64'(e));
        tick();
        chk("a_empty_count", 64'(a_count), 64'd0);
        chk("a_empty_valid", 64'(a_out_valid), 64'd0);
        chk("a_stat_after_drain", 64'(a_stat_decoded), st(5));

        // ---- XLEN=64: daddu legal, illegal opcode halts ----
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_inst = I_DADDU; a_in_pc = 64'h500;
        tick();
        a_in_valid = 1'b0;
        e = '0; e.alu_op = ALU_ADD; e.writeenable = 1'b1; e.ignore_overflow = 1'b1;
        chk("a_daddu_except", 64'(a_out_except), 64'd0);
        chk("a_daddu_ctrl", 64'(a_out_ctrl), 64'(e));
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_inst = I_BAD; a_in_pc = 64'h504;
        tick();
        a_in_inst = I_LUI; a_in_pc = 64'h508;
        chk("a_bad_valid", 64'(a_out_valid), 64'd1);
        chk("a_bad_except", 64'(a_out_except), 64'd1);
        chk("a_bad_ctrl", 64'(a_out_ctrl), 64'd0);
        tick();
        chk("a_bad_count2", 64'(a_count), 64'd2);
        a_in_pc = 64'h50C; a_out_ready = 1'b1;
        tick();
        chk("a_halt_out_valid", 64'(a_out_valid), 64'd0);
        chk("a_halt_in_ready", 64'(a_in_ready), 64'd0);
        chk("a_halt_count", 64'(a_count), 64'd0);
        chk("a_halt_stat_dec", 64'(a_stat_decoded), st(7));
        chk("a_halt_stat_exc", 64'(a_stat_except), st(1));
        tick();
        chk("a_halt_hold_count", 64'(a_count), 64'd0);
        chk("a_halt_hold_in_ready", 64'(a_in_ready), 64'd0);
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        chk("a_resume_in_ready", 64'(a_in_ready), 64'd1);
        chk("a_resume_count", 64'(a_count), 64'd0);

        // ---- flush beats same-cycle push and pop ----
        a_in_valid = 1'b1; a_in_inst = I_LUI; a_in_pc = 64'h300;
        tick();
        a_in_inst = I_ADDU; a_in_pc = 64'h304;
        tick();
        chk("a_pre_flush_count", 64'(a_count), 64'd2);
        a_in_pc = 64'h308; a_out_ready = 1'b1; a_flush = 1'b1;
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        chk("a_flushprio_count", 64'(a_count), 64'd0);
        chk("a_flushprio_valid", 64'(a_out_valid), 64'd0);
        chk("a_flushprio_stat", 64'(a_stat_decoded), st(7));
        chk("a_flushprio_in_ready", 64'(a_in_ready), 64'd1);

        // ---- lui then eret from a clean reset; eret pop halts ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a_in_valid = 1'b1; a_in_inst = I_LUI; a_in_pc = 64'h400;
        tick();
        e = '0; e.alu_op = ALU_ADD; e.writeenable = 1'b1; e.rd_src = RD_FROM_RT;
        e.alu_src2 = SRC2_LUI;
        chk("a_lui_ctrl", 64'(a_out_ctrl), 64'(e));
        a_in_inst = I_ERET; a_in_pc = 64'h404; a_out_ready = 1'b1;
        tick();
        a_in_valid = 1'b0;
        e = '0; e.is_eret = 1'b1;
        chk("a_eret_count", 64'(a_count), 64'd1);
        chk("a_eret_pc", 64'(a_out_pc), 64'h404);
        chk("a_eret_except", 64'(a_out_except), 64'd0);
        chk("a_eret_ctrl", 64'(a_out_ctrl), 64'(e));
        tick();
        a_out_ready = 1'b0;
        chk("a_eret_halt_valid", 64'(a_out_valid), 64'd0);
        chk("a_eret_halt_in_ready", 64'(a_in_ready), 64'd0);
        chk("a_eret_stat_dec", 64'(a_stat_decoded), st(2));
        chk("a_eret_stat_exc", 64'(a_stat_except), st(0));

        // ---- reset out of HALT ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_in_ready", 64'(a_in_ready), 64'd1);
        chk("rst2_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst2_out_except", 64'(a_out_except), 64'd0);
        chk("rst2_out_ctrl", 64'(a_out_ctrl), 64'd0);
        chk("rst2_count", 64'(a_count), 64'd0);
        chk("rst2_stat_dec", 64'(a_stat_decoded), 64'd0);
        a_in_valid = 1'b1; a_in_inst = I_ADDU; a_in_pc = 64'h600;
        tick();
        a_in_valid = 1'b0;
        chk("rst2_run_valid", 64'(a_out_valid), 64'd1);
        chk("rst2_run_pc", 64'(a_out_pc), 64'h600);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
